// File: rtl/memory_pkg.sv
// Memory map constants and boot loader type definitions shared by the
// core memory subsystem and the image loader.
package memory_pkg;

  localparam int unsigned IMEM_BYTES     = 4096;
  localparam int unsigned DMEM_BYTES     = 4096;
  localparam int unsigned MEM_ADDR_WIDTH = 13;

  // Boot loader sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } boot_state_e;

  // Boot loader failure reasons, encoded as reported on err_code.
  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_STALL    = 2'd3
  } boot_err_e;

endpackage

// File: rtl/boot_loader_up_counter.sv
// UpCounter: free-running up counter with synchronous clear.
//   clk, rstn      : clock, async active-low reset
//   en             : count enable
//   clear          : synchronous clear, wins over en
//   count_val      : current count
//   overflow       : registered pulse when the count wraps
module UpCounter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clear,
  output logic [WIDTH-1:0] count_val,
  output logic             overflow
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_val <= '0;
      overflow  <= 1'b0;
    end else if (clear) begin
      count_val <= '0;
      overflow  <= 1'b0;
    end else begin
      overflow <= en & (&count_val);
      if (en) begin
        count_val <= count_val + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/boot_loader.sv
// boot_loader: copies a 32-bit word stream into core memory, then launches
// the core with a one-cycle first_fetch_trigger at the programmed entry.
//   clk, rstn                    : clock, async active-low reset
//   start, load_base,
//   word_count, entry_addr       : load request (sampled in IDLE/DONE/ERROR)
//   s_valid, s_data, s_ready     : input word stream
//   mem_we, mem_addr, mem_wdata,
//   mem_ready                    : memory write port
//   first_fetch_addr,
//   first_fetch_trigger          : core launch
//   busy, done, error, err_code  : status
module boot_loader
  import memory_pkg::*;
#(
  parameter int unsigned ADDR_W        = MEM_ADDR_WIDTH,
  parameter int unsigned MEM_BYTES     = IMEM_BYTES + DMEM_BYTES,
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W-1:0] word_count,
  input  logic [ADDR_W-1:0] entry_addr,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] first_fetch_addr,
  output logic              first_fetch_trigger,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam int unsigned SUM_W = ADDR_W + 3;
  localparam int unsigned CNT_W = $clog2(STALL_TIMEOUT + 1);

  boot_state_e       state_q, state_n;
  boot_err_e         err_q, err_n;
  logic [ADDR_W-1:0] ptr_n, rem_q, rem_n, entry_q, entry_n, ffa_n;
  logic [SUM_W-1:0]  end_sum;
  logic [CNT_W-1:0]  stall_cnt;
  logic              stall_ovf_unused;
  logic              in_load, beat, start_ok, stall_hit;

  // Stream and memory handshakes pass straight through while loading.
  assign in_load   = (state_q == ST_LOAD);
  assign s_ready   = in_load & mem_ready;
  assign mem_we    = in_load & s_valid;
  assign mem_wdata = in_load ? s_data : 32'd0;
  assign beat      = in_load & s_valid & mem_ready;
  assign err_code  = 2'(err_q);

  // Range check at ADDR_W+3 bits so base + 4*count cannot wrap.
  assign end_sum = SUM_W'(load_base) + (SUM_W'(word_count) << 2);

  // Stall timer: counts consecutive LOAD cycles without a beat.
  UpCounter #(
    .WIDTH (CNT_W)
  ) u_stall_timer (
    .clk       (clk),
    .rstn      (rstn),
    .en        (in_load),
    .clear     (beat | ~in_load),
    .count_val (stall_cnt),
    .overflow  (stall_ovf_unused)
  );

  // The counter reaches STALL_TIMEOUT on this edge when it holds one less
  // and no beat lands, so the abort takes effect on that same edge.
  assign stall_hit = (stall_cnt == CNT_W'(STALL_TIMEOUT - 1)) & ~beat;

  assign start_ok = start &
                    ((state_q == ST_IDLE) | (state_q == ST_DONE) | (state_q == ST_ERROR));

  // Next-state and datapath update.
  always_comb begin
    state_n = state_q;
    err_n   = err_q;
    ptr_n   = mem_addr;
    rem_n   = rem_q;
    entry_n = entry_q;

    unique case (state_q)
      ST_LOAD: begin
        if (beat) begin
          ptr_n = mem_addr + ADDR_W'(4);
          rem_n = rem_q - ADDR_W'(1);
          if (rem_q == ADDR_W'(1)) begin
            state_n = ST_LAUNCH;
          end
        end else if (stall_hit) begin
          state_n = ST_ERROR;
          err_n   = ERR_STALL;
        end
      end
      ST_LAUNCH: state_n = ST_DONE;
      default: ;
    endcase

    // A new request clears prior status and re-checks in the same cycle.
    if (start_ok) begin
      err_n   = ERR_NONE;
      entry_n = entry_addr;
      if ((load_base[1:0] != 2'b00) || (entry_addr[1:0] != 2'b00)) begin
        state_n = ST_ERROR;
        err_n   = ERR_MISALIGN;
      end else if (end_sum > SUM_W'(MEM_BYTES)) begin
        state_n = ST_ERROR;
        err_n   = ERR_RANGE;
      end else if (word_count == '0) begin
        state_n = ST_LAUNCH;
      end else begin
        state_n = ST_LOAD;
        ptr_n   = load_base;
        rem_n   = word_count;
      end
    end

    ffa_n = (state_n == ST_LAUNCH) ? entry_n : first_fetch_addr;
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q             <= ST_IDLE;
      err_q               <= ERR_NONE;
      mem_addr            <= '0;
      rem_q               <= '0;
      entry_q             <= '0;
      first_fetch_addr    <= '0;
      first_fetch_trigger <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
      error               <= 1'b0;
    end else begin
      state_q             <= state_n;
      err_q               <= err_n;
      mem_addr            <= ptr_n;
      rem_q               <= rem_n;
      entry_q             <= entry_n;
      first_fetch_addr    <= ffa_n;
      first_fetch_trigger <= (state_n == ST_LAUNCH);
      busy                <= (state_n == ST_LOAD) | (state_n == ST_LAUNCH);
      done                <= (state_n == ST_DONE);
      error               <= (state_n == ST_ERROR);
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: expected memory writes and launch
// addresses are queued as requests are issued and retired by a monitor.
module tb_boot_loader;
  import memory_pkg::*;

  localparam int unsigned AW = MEM_ADDR_WIDTH;
  localparam int unsigned MB = IMEM_BYTES + DMEM_BYTES;
  localparam int unsigned ST = 8;

  logic          clk = 1'b0;
  logic          rstn, start, s_valid, mem_ready;
  logic [AW-1:0] load_base, word_count, entry_addr;
  logic [31:0]   s_data;
  logic          s_ready, mem_we, first_fetch_trigger, busy, done, error;
  logic [AW-1:0] mem_addr, first_fetch_addr;
  logic [31:0]   mem_wdata;
  logic [1:0]    err_code;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] tq[$];

  boot_loader #(.STALL_TIMEOUT(ST)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .start               (start),
    .load_base           (load_base),
    .word_count          (word_count),
    .entry_addr          (entry_addr),
    .s_valid             (s_valid),
    .s_data              (s_data),
    .s_ready             (s_ready),
    .mem_we              (mem_we),
    .mem_addr            (mem_addr),
    .mem_wdata           (mem_wdata),
    .mem_ready           (mem_ready),
    .first_fetch_addr    (first_fetch_addr),
    .first_fetch_trigger (first_fetch_trigger),
    .busy                (busy),
    .done                (done),
    .error               (error),
    .err_code            (err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    wq.push_back(e);
  endtask

  // Pulse start for one accepting edge.
  task automatic request(input logic [AW-1:0] b, input logic [AW-1:0] n, input logic [AW-1:0] e);
    load_base  = b;
    word_count = n;
    entry_addr = e;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  // Monitor: every accepted write and every trigger must be expected.
  always @(negedge clk) begin
    if (rstn) begin
      if (mem_we && mem_ready) begin
        chk("wr_expected", 64'(wq.size() != 0), 64'd1);
        if (wq.size() != 0) begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_addr", 64'(mem_addr), 64'(e.addr));
          chk("wr_data", 64'(mem_wdata), 64'(e.data));
        end
      end
      if (first_fetch_trigger) begin
        chk("trig_expected", 64'(tq.size() != 0), 64'd1);
        if (tq.size() != 0) begin
          chk("trig_addr", 64'(first_fetch_addr), 64'(tq.pop_front()));
        end
      end
    end
  end

  initial begin
    logic [31:0] nom [4];
    logic [31:0] bpd [3];
    logic [7:0]  vpat;
    logic [7:0]  rpat;
    int          k;
    logic        b;

    nom[0] = 32'h0050_0093; nom[1] = 32'h00A0_0113;
    nom[2] = 32'h0020_81B3; nom[3] = 32'h0000_0073;
    bpd[0] = 32'hDEAD_0001; bpd[1] = 32'hDEAD_0002; bpd[2] = 32'hDEAD_0003;

    rstn = 1'b0; start = 1'b0; s_valid = 1'b0; mem_ready = 1'b0;
    s_data = '0; load_base = '0; word_count = '0; entry_addr = '0;

    // Reset values.
    #12;
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_done",  64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_code",  64'(err_code), 64'd0);
    chk("rst_trig",  64'(first_fetch_trigger), 64'd0);
    chk("rst_ffa",   64'(first_fetch_addr), 64'd0);
    chk("rst_addr",  64'(mem_addr), 64'd0);
    chk("rst_we",    64'(mem_we), 64'd0);
    rstn = 1'b1;
    step();

    // Nominal 4-word load at 0x0, back-to-back.
    for (int i = 0; i < 4; i++) push_wr(32'(4 * i), nom[i]);
    tq.push_back(32'h0);
    mem_ready = 1'b1;
    s_valid   = 1'b1;
    s_data    = nom[0];
    request(AW'(0), AW'(4), AW'(0));
    chk("nom_busy", 64'(busy), 64'd1);
    chk("nom_we_first", 64'(mem_we), 64'd1);
    for (int i = 0; i < 4; i++) begin
      s_data = nom[i];
      chk("nom_ready", 64'(s_ready), 64'd1);
      step();
    end
    s_valid = 1'b0;
    chk("nom_trig", 64'(first_fetch_trigger), 64'd1);
    chk("nom_done_early", 64'(done), 64'd0);
    step();
    chk("nom_done", 64'(done), 64'd1);
    chk("nom_trig_pulse", 64'(first_fetch_trigger), 64'd0);
    chk("nom_busy_off", 64'(busy), 64'd0);
    chk("nom_ffa_hold", 64'(first_fetch_addr), 64'd0);

    // Backpressure: 3 words at 0x100 with valid gaps and ready stalls.
    for (int i = 0; i < 3; i++) push_wr(32'h100 + 32'(4 * i), bpd[i]);
    tq.push_back(32'h40);
    vpat = 8'b1101_0111;
    rpat = 8'b1111_1001;
    request(AW'(32'h100), AW'(3), AW'(32'h40));
    k = 0;
    for (int c = 0; c < 8 && k < 3; c++) begin
      s_valid   = vpat[c];
      mem_ready = rpat[c];
      s_data    = bpd[k];
      #1;
      chk("bp_addr", 64'(mem_addr), 64'(32'h100 + 32'(4 * k)));
      chk("bp_data", 64'(mem_wdata), 64'(bpd[k]));
      chk("bp_we", 64'(mem_we), 64'(vpat[c]));
      chk("bp_ready", 64'(s_ready), 64'(rpat[c]));
      b = vpat[c] & rpat[c];
      step();
      if (b) k++;
    end
    chk("bp_beats", 64'(k), 64'd3);
    s_valid = 1'b0; mem_ready = 1'b1;
    chk("bp_trig", 64'(first_fetch_trigger), 64'd1);
    step();
    chk("bp_done", 64'(done), 64'd1);

    // Misaligned base, then misaligned entry: no writes, no trigger.
    s_valid = 1'b1;
    request(AW'(2), AW'(1), AW'(0));
    chk("mis_error", 64'(error), 64'd1);
    chk("mis_code",  64'(err_code), 64'd1);
    chk("mis_done",  64'(done), 64'd0);
    chk("mis_we",    64'(mem_we), 64'd0);
    step();
    request(AW'(0), AW'(1), AW'(6));
    chk("mis_entry_code", 64'(err_code), 64'd1);
    chk("mis_entry_busy", 64'(busy), 64'd0);

    // Range overflow at the top of memory.
    request(AW'(MB - 4), AW'(2), AW'(0));
    chk("rng_error", 64'(error), 64'd1);
    chk("rng_code",  64'(err_code), 64'd2);
    step();

    // Exact fit at the top of memory loads and clears the error.
    push_wr(32'(MB - 4), 32'hCAFE_F00D);
    tq.push_back(32'h10);
    s_data = 32'hCAFE_F00D;
    request(AW'(MB - 4), AW'(1), AW'(32'h10));
    chk("fit_error_clr", 64'(error), 64'd0);
    chk("fit_code_clr",  64'(err_code), 64'd0);
    step();
    s_valid = 1'b0;
    chk("fit_trig", 64'(first_fetch_trigger), 64'd1);
    step();
    chk("fit_done", 64'(done), 64'd1);

    // Zero-length load launches straight away.
    tq.push_back(32'h80);
    request(AW'(0), AW'(0), AW'(32'h80));
    chk("zero_trig", 64'(first_fetch_trigger), 64'd1);
    chk("zero_ffa",  64'(first_fetch_addr), 64'h80);
    chk("zero_done_clr", 64'(done), 64'd0);
    step();
    chk("zero_done", 64'(done), 64'd1);

    // Stall after 1 of 3 words: abort on the ST-th idle cycle.
    push_wr(32'h200, 32'h1111_2222);
    s_valid = 1'b1;
    s_data  = 32'h1111_2222;
    request(AW'(32'h200), AW'(3), AW'(0));
    step();
    s_valid = 1'b0;
    for (int i = 1; i < int'(ST); i++) begin
      step();
      chk("stall_pending", 64'(error), 64'd0);
    end
    step();
    chk("stall_error", 64'(error), 64'd1);
    chk("stall_code",  64'(err_code), 64'd3);
    chk("stall_busy",  64'(busy), 64'd0);
    s_valid = 1'b1;
    #1;
    chk("stall_no_we", 64'(mem_we), 64'd0);

    // Restart after the timeout loads normally.
    push_wr(32'h300, 32'hAAAA_0000);
    push_wr(32'h304, 32'hAAAA_0001);
    tq.push_back(32'h300);
    s_data = 32'hAAAA_0000;
    request(AW'(32'h300), AW'(2), AW'(32'h300));
    chk("re_error_clr", 64'(error), 64'd0);
    step();
    s_data = 32'hAAAA_0001;
    step();
    s_valid = 1'b0;
    chk("re_trig", 64'(first_fetch_trigger), 64'd1);
    step();
    chk("re_done", 64'(done), 64'd1);

    // Reset mid-load: asynchronous clear, no trigger afterwards.
    push_wr(32'h0, 32'h5555_0000);
    s_valid = 1'b1;
    s_data  = 32'h5555_0000;
    request(AW'(0), AW'(4), AW'(32'h20));
    step();
    s_valid = 1'b0;
    #1;
    rstn = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_addr", 64'(mem_addr), 64'd0);
    chk("mid_rst_we",   64'(mem_we), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    step();
    rstn = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_trig", 64'(first_fetch_trigger), 64'd0);
    end
    chk("post_rst_we", 64'(mem_we), 64'd0);

    chk("wq_drained", 64'(wq.size()), 64'd0);
    chk("tq_drained", 64'(tq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
